// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared types and constants for the divider scheduler
package div_sched_pkg;

    // Operand and quotient widths of the shared divider
    localparam int OPW = 16;
    localparam int QW  = 8;

    // Quotient returned on timeout or rejected zero divisor
    localparam logic [QW-1:0] ERR_QUOT = 8'hFF;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/div_rr_arb.sv
// rtl/div_rr_arb.sv - round-robin selector, search starts one past the pointer
module div_rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            valid
);

    // Lowest requester above the pointer wins; otherwise wrap to the lowest at or below it
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i] && (i > int'(ptr))) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i] && (i <= int'(ptr))) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// rtl/div_sched.sv - shares one divider among NREQ requesters; DIV_SCHED_ZERO_CHK_EN short-circuits zero divisors
module div_sched
    import div_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [OPW*NREQ-1:0] req_dividend,
    input  logic [OPW*NREQ-1:0] req_divisor,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [QW-1:0]       rsp_quotient,
    output logic                rsp_err,
    output logic                div_en,
    output logic [OPW-1:0]      div_dividend,
    output logic [OPW-1:0]      div_divisor,
    input  logic [QW-1:0]       div_quotient,
    input  logic                div_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] owner;
    logic [QW-1:0]   res_q;
    logic            res_err;

    logic [NREQ-1:0] arb_grant;
    logic            arb_valid;
    logic [PW-1:0]   win_idx;
    logic [OPW-1:0]  sel_dividend;
    logic [OPW-1:0]  sel_divisor;

    div_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Encode the one-hot winner and mux its operand slices
    always_comb begin
        win_idx      = '0;
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                win_idx      = PW'(i);
                sel_dividend = req_dividend[OPW*i +: OPW];
                sel_divisor  = req_divisor[OPW*i +: OPW];
            end
        end
    end

    // Scheduler FSM; every output is a registered pulse or a held operand
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            ptr          <= PTR_RST;
            cnt          <= '0;
            owner        <= '0;
            res_q        <= '0;
            res_err      <= 1'b0;
            gnt          <= '0;
            rsp_valid    <= '0;
            rsp_quotient <= '0;
            rsp_err      <= 1'b0;
            div_en       <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            gnt          <= '0;
            rsp_valid    <= '0;
            rsp_quotient <= '0;
            rsp_err      <= 1'b0;
            div_en       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        gnt          <= arb_grant;
                        owner        <= arb_grant;
                        ptr          <= win_idx;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
`ifdef DIV_SCHED_ZERO_CHK_EN
                        if (sel_divisor == '0) begin
                            res_q   <= ERR_QUOT;
                            res_err <= 1'b1;
                            state   <= ST_RESP;
                        end else begin
                            state   <= ST_ISSUE;
                        end
`else
                        state        <= ST_ISSUE;
`endif
                    end
                end
                ST_ISSUE: begin
                    div_en <= 1'b1;
                    cnt    <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done wins over a timeout landing in the same cycle
                    if (div_done) begin
                        res_q   <= div_quotient;
                        res_err <= 1'b0;
                        state   <= ST_RESP;
                    end else if (cnt == TMAX) begin
                        res_q   <= ERR_QUOT;
                        res_err <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid    <= owner;
                    rsp_quotient <= res_q;
                    rsp_err      <= res_err;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
